sdram_bridge_writer: RTL and testbench

// - Buffers 32-bit write words from the host data bridge (ROM/save loading) and replays them as

---
 rtl/sdram_bridge_writer.sv | 139 +++++++++++++
 tb/tb_sdram_bridge_writer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bridge_writer.sv
// Buffers host-bridge write words in a small FIFO and replays each one as a single
// 32-bit write request on the SDRAM controller channel, one request outstanding at a time.
module sdram_bridge_writer #(
  parameter int FIFO_AW   = 3,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [26:0] in_addr,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        loading,
  output logic [25:0] sdr_addr,
  output logic [31:0] sdr_din,
  output logic        sdr_req,
  output logic        sdr_rnw,
  input  logic        sdr_ready,
  output logic        done,
  output logic        overflow,
  output logic        misalign,
  output logic [15:0] words_written
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = 25 + 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t               state_reg;
  logic [EW-1:0]        fifo_mem_reg [DEPTH];
  logic [FIFO_AW:0]     wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]     wr_ptr_next, rd_ptr_next;
  logic                 in_ready_reg, done_reg, overflow_reg, misalign_reg;
  logic                 sdr_req_reg;
  logic [25:0]          sdr_addr_reg;
  logic [31:0]          sdr_din_reg;
  logic [15:0]          words_reg;
  logic [31:0]          data_swapped;
  logic [EW-1:0]        head;
  logic                 full, empty, full_next, empty_next;
  logic                 push, pop, idle_next;

  // Byte lane reordering for big-endian bridge data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_swap
    if (BYTE_SWAP) begin : g_on
      assign data_swapped[8*gi +: 8] = in_data[8*(3-gi) +: 8];
    end else begin : g_off
      assign data_swapped[8*gi +: 8] = in_data[8*gi +: 8];
    end
  end

  assign full  = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                 (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign push  = in_valid && !full;
  assign pop   = (state_reg == IDLE) && !empty;
  assign head  = fifo_mem_reg[rd_ptr_reg[FIFO_AW-1:0]];

  always_comb begin
    wr_ptr_next = wr_ptr_reg + {{FIFO_AW{1'b0}}, push};
    rd_ptr_next = rd_ptr_reg + {{FIFO_AW{1'b0}}, pop};
  end

  assign full_next  = (wr_ptr_next[FIFO_AW] != rd_ptr_next[FIFO_AW]) &&
                      (wr_ptr_next[FIFO_AW-1:0] == rd_ptr_next[FIFO_AW-1:0]);
  assign empty_next = (wr_ptr_next == rd_ptr_next);
  // FSM will be in IDLE next cycle: either it stays there with nothing to pop, or WAIT completes.
  assign idle_next  = ((state_reg == IDLE) && empty) || ((state_reg == WAIT) && sdr_ready);

  always_ff @(posedge clk) begin
    if (push) fifo_mem_reg[wr_ptr_reg[FIFO_AW-1:0]] <= {in_addr[26:2], data_swapped};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      in_ready_reg <= 1'b1;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      in_ready_reg <= !full_next;
      done_reg     <= !loading && empty_next && idle_next;
      if (in_valid && full) overflow_reg <= 1'b1;
      if (push && (in_addr[1:0] != 2'b00)) misalign_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      sdr_req_reg  <= 1'b0;
      sdr_addr_reg <= '0;
      sdr_din_reg  <= '0;
      words_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!empty) begin
            sdr_addr_reg <= {head[EW-1:32], 1'b0};
            sdr_din_reg  <= head[31:0];
            sdr_req_reg  <= 1'b1;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          sdr_req_reg <= 1'b0;
          state_reg   <= WAIT;
        end
        WAIT: begin
          // The controller may stall indefinitely (refresh/arbitration); no timeout.
          if (sdr_ready) begin
            words_reg <= words_reg + 16'd1;
            state_reg <= IDLE;
          end
        end
        default: begin
          sdr_req_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_reg;
  assign done          = done_reg;
  assign overflow      = overflow_reg;
  assign misalign      = misalign_reg;
  assign sdr_req       = sdr_req_reg;
  assign sdr_addr      = sdr_addr_reg;
  assign sdr_din       = sdr_din_reg;
  assign sdr_rnw       = 1'b0;
  assign words_written = words_reg;

endmodule

// File: tb/tb_sdram_bridge_writer.sv
// Bench for sdram_bridge_writer: a queue of expected SDRAM writes plus a behavioural
// controller that answers requests after a programmable latency.
module tb_sdram_bridge_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [26:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        loading = 1'b0;
  logic [25:0] sdr_addr;
  logic [31:0] sdr_din;
  logic        sdr_req;
  logic        sdr_rnw;
  logic        sdr_ready = 1'b0;
  logic        done;
  logic        overflow;
  logic        misalign;
  logic [15:0] words_written;

  always #5 clk = ~clk;

  sdram_bridge_writer #(.FIFO_AW(3), .BYTE_SWAP(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
    .loading(loading),
    .sdr_addr(sdr_addr), .sdr_din(sdr_din), .sdr_req(sdr_req), .sdr_rnw(sdr_rnw),
    .sdr_ready(sdr_ready),
    .done(done), .overflow(overflow), .misalign(misalign), .words_written(words_written)
  );

  typedef struct {
    logic [25:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   n_chk = 0;
  int   n_bad = 0;
  int   exp_words = 0;
  bit   exp_ovf = 0;
  bit   exp_mis = 0;
  bit   hold_ready = 0;
  bit   stray = 0;
  bit   outstanding = 0;
  bit   abandoned = 0;
  int   fixed_lat = 0;
  int   lat_cnt = 0;
  int   req_count = 0;
  logic [25:0] lat_a;
  logic [31:0] lat_d;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [26:0] a, input logic [31:0] d);
    wr_t e;
    e.a = 26'((a & ~27'd3) >> 1);
    e.d = swap32(d);
    exp_q.push_back(e);
    if ((a & 27'd3) != 27'd0) exp_mis = 1;
  endtask

  task automatic send(input logic [26:0] a, input logic [31:0] d, input bit acc);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    if (acc) expect_word(a, d);
    else exp_ovf = 1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || outstanding) && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
    chk("words_written", 64'(words_written), 64'(exp_words[15:0]));
  endtask

  // Behavioural SDRAM controller and write scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      sdr_ready = 1'b0;
      if (reset_n && sdr_req) begin
        req_count++;
        chk("req_while_outstanding", 64'(outstanding), 64'd0);
        chk("sdr_rnw", 64'(sdr_rnw), 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 64'(sdr_addr), 64'h3FFFFFFFFFFFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sdr_addr", 64'(sdr_addr), 64'(mon_e.a));
          chk("sdr_din", 64'(sdr_din), 64'(mon_e.d));
          $display("write addr=%07h data=%08h", sdr_addr, sdr_din);
        end
        outstanding = 1;
        lat_a = sdr_addr;
        lat_d = sdr_din;
        lat_cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(6, 1));
      end else if (outstanding) begin
        if (!reset_n) abandoned = 1;
        if (!abandoned) begin
          chk("hold_addr", 64'(sdr_addr), 64'(lat_a));
          chk("hold_din", 64'(sdr_din), 64'(lat_d));
        end
        if (!hold_ready) begin
          lat_cnt--;
          if (lat_cnt <= 0) begin
            sdr_ready = 1'b1;
            outstanding = 0;
            if (!abandoned) exp_words++;
            abandoned = 0;
          end
        end
      end else if (stray) begin
        sdr_ready = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] d;
    logic [26:0] a;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sdr_req", 64'(sdr_req), 64'd0);
    chk("rst_sdr_addr", 64'(sdr_addr), 64'd0);
    chk("rst_sdr_din", 64'(sdr_din), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_words", 64'(words_written), 64'd0);
    reset_n = 1'b1;
    tick();
    tick();
    chk("idle_done", 64'(done), 64'd1);

    // Single word with latency check
    fixed_lat = 3;
    send(27'h0000100, 32'h11223344, 1);
    chk("lat_n1_req", 64'(sdr_req), 64'd0);
    chk("lat_n1_done", 64'(done), 64'd0);
    tick();
    chk("lat_n2_req", 64'(sdr_req), 64'd1);
    chk("single_addr", 64'(sdr_addr), 64'h80);
    chk("single_din", 64'(sdr_din), 64'h44332211);
    drain(50);
    chk("single_count", 64'(words_written), 64'd1);
    chk("single_done", 64'(done), 64'd1);

    // Stall: ready withheld for 20+ cycles
    hold_ready = 1;
    base = req_count;
    send(27'($urandom) & ~27'd3, $urandom, 1);
    repeat (22) tick();
    chk("stall_pulses", 64'(req_count - base), 64'd1);
    hold_ready = 0;
    drain(50);

    // Randomized traffic
    fixed_lat = 0;
    for (int i = 0; i < 400; i++) begin
      loading = 1'($urandom_range(1, 0));
      if (in_ready && $urandom_range(2, 0) == 0) begin
        a = 27'($urandom) & ~27'd3;
        d = $urandom;
        in_valid = 1'b1;
        in_addr = a;
        in_data = d;
        expect_word(a, d);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    loading = 1'b0;
    drain(400);
    chk("rand_overflow", 64'(overflow), 64'(exp_ovf));
    chk("rand_misalign", 64'(misalign), 64'(exp_mis));
    chk("rand_done", 64'(done), 64'd1);

    // Fill: one word held in WAIT, then 8 more fill the FIFO, a 9th overflows
    hold_ready = 1;
    send(27'h0000200, 32'hA0A0A0A0, 1);
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      send(27'(27'h0001000 + 27'(i * 4)), 32'(32'hC0DE0000 + 32'(i)), 1);
      chk("fill_in_ready", 64'(in_ready), 64'(i < 7));
    end
    send(27'h0002000, 32'hDEADBEEF, 0);
    chk("fill_overflow", 64'(overflow), 64'(exp_ovf));
    chk("fill_in_ready_held", 64'(in_ready), 64'd0);
    hold_ready = 0;
    fixed_lat = 2;
    drain(200);
    chk("fill_in_ready_after", 64'(in_ready), 64'd1);

    // Misalign and stray ready in IDLE
    send(27'h0000102, 32'h0BADF00D, 1);
    chk("misalign_flag", 64'(misalign), 64'(exp_mis));
    tick();
    chk("misalign_addr", 64'(sdr_addr), 64'h80);
    drain(50);
    stray = 1;
    tick();
    tick();
    stray = 0;
    repeat (3) tick();
    chk("stray_count", 64'(words_written), 64'(exp_words[15:0]));

    // Done tracks the third completion after loading falls
    loading = 1'b1;
    tick();
    chk("done_loading", 64'(done), 64'd0);
    hold_ready = 1;
    for (int i = 0; i < 3; i++) send(27'(27'h0300000 + 27'(i * 4)), $urandom, 1);
    loading = 1'b0;
    tick();
    tick();
    chk("done_queued", 64'(done), 64'd0);
    base = exp_words;
    fixed_lat = 4;
    hold_ready = 0;
    for (int i = 0; i < 100 && exp_words < base + 3; i++) begin
      tick();
      chk("done_track", 64'(done), 64'(exp_words >= base + 3));
    end
    tick();
    chk("done_final", 64'(done), 64'd1);

    // Asynchronous reset while a request is outstanding
    hold_ready = 1;
    fixed_lat = 2;
    send(27'h0400000, $urandom, 1);
    send(27'h0400004, $urandom, 1);
    send(27'h0400008, $urandom, 1);
    repeat (3) tick();
    reset_n = 1'b0;
    exp_q.delete();
    exp_words = 0;
    exp_ovf = 0;
    exp_mis = 0;
    #2;
    chk("arst_sdr_req", 64'(sdr_req), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_words", 64'(words_written), 64'(exp_words));
    chk("arst_overflow", 64'(overflow), 64'(exp_ovf));
    chk("arst_misalign", 64'(misalign), 64'(exp_mis));
    chk("arst_sdr_addr", 64'(sdr_addr), 64'd0);
    tick();
    reset_n = 1'b1;
    hold_ready = 0;
    repeat (10) tick();
    chk("late_ready_delivered", 64'(outstanding), 64'd0);
    chk("late_ready_ignored", 64'(words_written), 64'(exp_words[15:0]));
    chk("post_rst_done", 64'(done), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
